l1_data_cache: RTL and testbench

- Level-1 data cache between the core's load/store port and the shared memory bus arbiter.
- Direct-mapped, write-back, write-allocate cache with 128-bit (16-byte) lines.
- Hits complete combinationally.
- Misses stall the core via blocking_n_o while the cache evicts (if dirty) and refills over the bus handshake.

---
 rtl/dcache_pkg.sv | 18 +
 rtl/dcache_line_ram.sv | 31 +++
 rtl/l1_data_cache.sv | 129 ++++++++++++
 tb/tb_l1_data_cache.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the L1 data cache: line geometry, field-width helper, FSM state.
package dcache_pkg;

    localparam int LINE_BITS  = 128;
    localparam int LINE_BYTES = LINE_BITS / 8;
    localparam int WORD_BITS  = 32;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL
    } dc_state_e;

    function automatic int tag_bits(input int addr_w, input int line_shift, input int index_w);
        return addr_w - line_shift - index_w;
    endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// Line data array: combinational read, synchronous full-line or byte-masked write.
module dcache_line_ram
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk_i,
    input  logic [INDEX_BITS-1:0] addr_i,
    input  logic                  line_we_i,
    input  logic [LINE_BITS-1:0]  line_data_i,
    input  logic [LINE_BYTES-1:0] byte_we_i,
    input  logic [LINE_BITS-1:0]  byte_data_i,
    output logic [LINE_BITS-1:0]  data_o
);

    logic [LINE_BITS-1:0] mem [2**INDEX_BITS];

    assign data_o = mem[addr_i];

    // A refill replaces the whole line; byte writes only apply when no refill is in flight.
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            mem[addr_i] <= line_data_i;
        end else begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (byte_we_i[b]) mem[addr_i][b*8 +: 8] <= byte_data_i[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/l1_data_cache.sv
// Direct-mapped write-back, write-allocate L1 data cache with 16-byte lines.
module l1_data_cache
    import dcache_pkg::*;
#(
    parameter int BUS_ADDRESS_WIDTH    = 20,
    parameter int BUS_DATA_WIDTH_SHIFT = 4,
    parameter int INDEX_BITS           = 6
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic                                              en_i,
    input  logic [31:2]                                       addr_i,
    input  logic [31:0]                                       data_i,
    input  logic [3:0]                                        write_en_i,
    output logic [31:0]                                       data_o,
    output logic                                              blocking_n_o,
    output logic                                              flushing_n_o,
    output logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT]   bus_addr_o,
    output logic [LINE_BITS-1:0]                              bus_data_o,
    output logic                                              bus_we_o,
    output logic                                              bus_valid_o,
    input  logic [LINE_BITS-1:0]                              bus_data_i,
    input  logic                                              bus_valid_i
);

    localparam int TAG_BITS = tag_bits(BUS_ADDRESS_WIDTH, BUS_DATA_WIDTH_SHIFT, INDEX_BITS);
    localparam int LINES    = 2**INDEX_BITS;

    dc_state_e state_q, state_d;

    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  unused_addr;

    assign offset      = addr_i[3:2];
    assign index       = addr_i[4+INDEX_BITS-1:4];
    assign req_tag     = addr_i[BUS_ADDRESS_WIDTH-1:4+INDEX_BITS];
    assign unused_addr = ^addr_i[31:BUS_ADDRESS_WIDTH];

    logic [LINES-1:0]    valid_q, dirty_q;
    logic [TAG_BITS-1:0] tag_q [LINES];
    logic [LINE_BITS-1:0] line_rd;

    logic hit, req, store_hit, wb_done, refill_done;
    logic [LINE_BYTES-1:0] byte_we;

    // Requests are masked during reset so the core sees a quiet, non-blocking cache.
    assign req       = en_i && !rst_i;
    assign hit       = valid_q[index] && (tag_q[index] == req_tag);
    assign store_hit = (state_q == IDLE) && req && hit && (write_en_i != 4'b0000);
    assign byte_we   = store_hit ? (LINE_BYTES'(write_en_i) << {offset, 2'b00}) : '0;
    assign data_o    = line_rd[{offset, 5'b00000} +: WORD_BITS];

    dcache_line_ram #(.INDEX_BITS(INDEX_BITS)) u_ram (
        .clk_i       (clk_i),
        .addr_i      (index),
        .line_we_i   (refill_done),
        .line_data_i (bus_data_i),
        .byte_we_i   (byte_we),
        .byte_data_i ({4{data_i}}),
        .data_o      (line_rd)
    );

    always_comb begin
        state_d      = state_q;
        blocking_n_o = 1'b1;
        flushing_n_o = 1'b1;
        bus_valid_o  = 1'b0;
        bus_we_o     = 1'b0;
        bus_data_o   = '0;
        bus_addr_o   = {req_tag, index};
        wb_done      = 1'b0;
        refill_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    blocking_n_o = 1'b0;
                    state_d      = (valid_q[index] && dirty_q[index]) ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                blocking_n_o = 1'b0;
                flushing_n_o = 1'b0;
                bus_valid_o  = 1'b1;
                bus_we_o     = 1'b1;
                bus_addr_o   = {tag_q[index], index};
                bus_data_o   = line_rd;
                if (bus_valid_i) begin
                    wb_done = 1'b1;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                blocking_n_o = 1'b0;
                bus_valid_o  = 1'b1;
                if (bus_valid_i) begin
                    refill_done = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (refill_done) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (wb_done) begin
            dirty_q[index] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (refill_done) tag_q[index] <= req_tag;
    end

endmodule

// File: tb/tb_l1_data_cache.sv
// Directed scoreboard bench for l1_data_cache: miss/refill, store hit, dirty eviction, idle, reset.
module tb_l1_data_cache;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         en_i;
    logic [31:2]  addr_i;
    logic [31:0]  data_i;
    logic [3:0]   write_en_i;
    logic [31:0]  data_o;
    logic         blocking_n_o, flushing_n_o, bus_we_o, bus_valid_o, bus_valid_i;
    logic [19:4]  bus_addr_o;
    logic [127:0] bus_data_o, bus_data_i;

    int total = 0;
    int bad   = 0;
    logic [127:0] exp_q [$];

    l1_data_cache dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .addr_i(addr_i), .data_i(data_i),
        .write_en_i(write_en_i), .data_o(data_o), .blocking_n_o(blocking_n_o),
        .flushing_n_o(flushing_n_o), .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
        .bus_we_o(bus_we_o), .bus_valid_o(bus_valid_o), .bus_data_i(bus_data_i),
        .bus_valid_i(bus_valid_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic exp(input logic [127:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs);
        logic [127:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: observed=%h but scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic req(input logic en, input logic [31:0] baddr, input logic [3:0] we, input logic [31:0] d);
        en_i = en; addr_i = baddr[31:2]; write_en_i = we; data_i = d;
    endtask

    localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE_B = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

    initial begin
        rst_i = 1'b1; bus_valid_i = 1'b0; bus_data_i = '0;
        req(1'b0, 32'h0, 4'h0, 32'h0);
        step(); step();
        exp(128'd0); chk("rst_bus_valid", 128'(bus_valid_o));
        exp(128'd0); chk("rst_bus_we",    128'(bus_we_o));
        exp(128'd0); chk("rst_bus_data",  bus_data_o);
        exp(128'd1); chk("rst_blocking",  128'(blocking_n_o));
        exp(128'd1); chk("rst_flushing",  128'(flushing_n_o));
        rst_i = 1'b0;
        step();

        // clean miss on 0x00100
        req(1'b1, 32'h00100, 4'h0, 32'h0); #1;
        exp(128'd0); chk("miss_detect_blocking", 128'(blocking_n_o));
        step();
        exp(128'd1);      chk("refill_bus_valid", 128'(bus_valid_o));
        exp(128'd0);      chk("refill_bus_we",    128'(bus_we_o));
        exp(128'h0010);   chk("refill_bus_addr",  128'(bus_addr_o));
        exp(128'd1);      chk("refill_flushing",  128'(flushing_n_o));
        exp(128'd0);      chk("refill_blocking",  128'(blocking_n_o));
        bus_valid_i = 1'b1; bus_data_i = LINE_A;
        step();
        bus_valid_i = 1'b0; bus_data_i = '0; #1;
        exp(128'd1);          chk("hit_blocking",  128'(blocking_n_o));
        exp(128'h11111111);   chk("hit_word0",     128'(data_o));
        exp(128'd0);          chk("hit_bus_valid", 128'(bus_valid_o));
        req(1'b1, 32'h0010C, 4'h0, 32'h0); #1;
        exp(128'h44444444);   chk("hit_word3",     128'(data_o));

        // store hit, byte 0
        step();
        req(1'b1, 32'h00100, 4'b0001, 32'h000000AB); #1;
        exp(128'd1); chk("store_blocking",  128'(blocking_n_o));
        exp(128'd0); chk("store_bus_valid", 128'(bus_valid_o));
        step();
        req(1'b1, 32'h00100, 4'h0, 32'h0); #1;
        exp(128'h111111AB); chk("load_after_store", 128'(data_o));
        req(1'b1, 32'h00108, 4'h0, 32'h0); #1;
        exp(128'h33333333); chk("other_word_untouched", 128'(data_o));

        // conflicting dirty miss on 0x00500
        step();
        req(1'b1, 32'h00500, 4'h0, 32'h0); #1;
        exp(128'd0); chk("dirty_detect_blocking", 128'(blocking_n_o));
        step();
        exp(128'd1);      chk("wb_bus_valid", 128'(bus_valid_o));
        exp(128'd1);      chk("wb_bus_we",    128'(bus_we_o));
        exp(128'd0);      chk("wb_flushing",  128'(flushing_n_o));
        exp(128'h0010);   chk("wb_bus_addr",  128'(bus_addr_o));
        exp(128'h44444444_33333333_22222222_111111AB); chk("wb_bus_data", bus_data_o);
        step();
        exp(128'd1);      chk("wb_held_valid", 128'(bus_valid_o));
        exp(128'h0010);   chk("wb_held_addr",  128'(bus_addr_o));
        bus_valid_i = 1'b1;
        step();
        bus_valid_i = 1'b0; #1;
        exp(128'd1);      chk("rf2_bus_valid", 128'(bus_valid_o));
        exp(128'd0);      chk("rf2_bus_we",    128'(bus_we_o));
        exp(128'h0050);   chk("rf2_bus_addr",  128'(bus_addr_o));
        exp(128'd1);      chk("rf2_flushing",  128'(flushing_n_o));
        exp(128'd0);      chk("rf2_bus_data",  bus_data_o);
        bus_valid_i = 1'b1; bus_data_i = LINE_B;
        step();
        bus_valid_i = 1'b0; bus_data_i = '0; #1;
        exp(128'd1);        chk("rf2_hit_blocking", 128'(blocking_n_o));
        exp(128'hAAAAAAAA); chk("rf2_hit_word0",    128'(data_o));

        // idle with missing addresses and stray bus pulses
        step();
        req(1'b0, 32'h00300, 4'h0, 32'h0); bus_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp(128'd0); chk("idle_bus_valid", 128'(bus_valid_o));
            exp(128'd1); chk("idle_blocking",  128'(blocking_n_o));
            step();
        end
        bus_valid_i = 1'b0;
        req(1'b1, 32'h00504, 4'h0, 32'h0); #1;
        exp(128'd1);        chk("idle_no_change_hit", 128'(blocking_n_o));
        exp(128'hBBBBBBBB); chk("idle_no_change_data", 128'(data_o));

        // reset during REFILL (victim 0x00500 is clean)
        step();
        req(1'b1, 32'h00900, 4'h0, 32'h0); #1;
        exp(128'd0); chk("clean_victim_detect", 128'(blocking_n_o));
        step();
        exp(128'd1); chk("clean_victim_refill", 128'(bus_valid_o));
        exp(128'd0); chk("clean_victim_we",     128'(bus_we_o));
        rst_i = 1'b1; #1;
        exp(128'd0); chk("async_rst_bus_valid", 128'(bus_valid_o));
        exp(128'd1); chk("async_rst_blocking",  128'(blocking_n_o));
        step();
        rst_i = 1'b0;
        req(1'b1, 32'h00100, 4'h0, 32'h0); #1;
        exp(128'd0); chk("post_rst_miss", 128'(blocking_n_o));
        step();
        exp(128'd1);    chk("post_rst_refill_valid", 128'(bus_valid_o));
        exp(128'd0);    chk("post_rst_refill_we",    128'(bus_we_o));
        exp(128'h0010); chk("post_rst_refill_addr",  128'(bus_addr_o));
        bus_valid_i = 1'b1; bus_data_i = LINE_B;
        step();
        bus_valid_i = 1'b0; #1;
        exp(128'hAAAAAAAA); chk("post_rst_hit_word0", 128'(data_o));
        req(1'b0, 32'h0, 4'h0, 32'h0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
